// File: rtl/hydra_pkg.sv
// Shared definitions for the 16-port switch fabric: port counts, arbiter
// state encoding and the one-hot to index helper also used by mux_16.
package hydra_pkg;

  localparam int PORT_NUM   = 16;
  localparam int PORT_IDX_W = 4;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  function automatic logic [PORT_IDX_W-1:0] onehot16_to_idx(input logic [PORT_NUM-1:0] oh);
    logic [PORT_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (oh[i]) idx = idx | PORT_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick_16.sv
// Combinational rotate-priority encoder: returns the first set bit of
// req_masked searching ptr, ptr+1, ... ptr+15 (modulo 16).
module rr_pick_16
  import hydra_pkg::*;
(
  input  logic [PORT_NUM-1:0]   req_masked,
  input  logic [PORT_IDX_W-1:0] ptr,
  output logic [PORT_NUM-1:0]   pick_oh,
  output logic [PORT_IDX_W-1:0] pick_idx,
  output logic                  pick_any
);

  logic [2*PORT_NUM-1:0]   req_dbl;
  logic [PORT_NUM-1:0]     req_rot;
  logic [PORT_IDX_W-1:0]   offset;

  // Bit i of req_rot is request (ptr + i) mod 16, so the lowest set bit wins.
  assign req_dbl = {req_masked, req_masked} >> ptr;
  assign req_rot = req_dbl[PORT_NUM-1:0];

  always_comb begin
    offset = '0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (req_rot[i]) offset = PORT_IDX_W'(i);
    end
  end

  assign pick_any = |req_masked;
  assign pick_idx = ptr + offset;
  assign pick_oh  = pick_any ? (PORT_NUM'(1) << pick_idx) : '0;

endmodule

// File: rtl/rr_arbiter_16.sv
// Packet-locked round-robin arbiter for 16 ports; all outputs registered.
// Optional hold watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_16
  import hydra_pkg::*;
#(
  parameter int MAX_HOLD = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_NUM-1:0]   req,
  input  logic [PORT_NUM-1:0]   eop,
  output logic [PORT_NUM-1:0]   grant,
  output logic                  grant_vld,
  output logic [PORT_IDX_W-1:0] grant_idx,
  output logic                  timeout
);

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_arbiter_16: MAX_HOLD must be at least 2");
  end

  arb_state_t              state, state_next;
  logic [PORT_IDX_W-1:0]   ptr, ptr_next;
  logic [PORT_NUM-1:0]     grant_next;
  logic [PORT_IDX_W-1:0]   idx_next;
  logic [PORT_IDX_W-1:0]   after_winner;
  logic [PORT_NUM-1:0]     pick_req;
  logic [PORT_IDX_W-1:0]   pick_ptr;
  logic [PORT_NUM-1:0]     pick_oh;
  logic [PORT_IDX_W-1:0]   pick_idx;
  logic                    pick_any;
  logic                    normal_rel;
  logic                    hold_expired;
  logic                    new_grant;

  assign after_winner = grant_idx + 1'b1;
  // Dropping req without eop is an abort; eop only counts while req is held.
  assign normal_rel   = (state == ARB_LOCK) && (!req[grant_idx] || eop[grant_idx]);

  // While locked, the picker already looks past the current winner so a
  // release can hand over to the next port with no idle bubble.
  assign pick_req = (state == ARB_LOCK) ? (req & ~grant) : req;
  assign pick_ptr = (state == ARB_LOCK) ? after_winner : ptr;

  rr_pick_16 u_pick (
    .req_masked (pick_req),
    .ptr        (pick_ptr),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_any   (pick_any)
  );

  always_comb begin
    state_next = state;
    grant_next = grant;
    idx_next   = grant_idx;
    ptr_next   = ptr;
    new_grant  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_next = pick_oh;
          idx_next   = pick_idx;
          state_next = ARB_LOCK;
          new_grant  = 1'b1;
        end
      end
      ARB_LOCK: begin
        if (normal_rel || hold_expired) begin
          ptr_next = after_winner;
          if (pick_any) begin
            grant_next = pick_oh;
            idx_next   = pick_idx;
            new_grant  = 1'b1;
          end else begin
            grant_next = '0;
            idx_next   = '0;
            state_next = ARB_IDLE;
          end
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      grant_vld <= 1'b0;
      grant_idx <= '0;
      ptr       <= '0;
    end else begin
      state     <= state_next;
      grant     <= grant_next;
      grant_vld <= |grant_next;
      grant_idx <= idx_next;
      ptr       <= ptr_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_reg;

  assign hold_expired = (state == ARB_LOCK) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= hold_expired && !normal_rel;
      if (new_grant) hold_cnt <= '0;
      else if (state == ARB_LOCK) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign timeout = timeout_reg;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed self-checking bench for rr_arbiter_16; define ARB_TIMEOUT_EN to
// exercise the watchdog with MAX_HOLD=8.
module tb_rr_arbiter_16;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 8;
`else
  localparam int TB_MAX_HOLD = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [15:0] eop = '0;
  logic [15:0] grant;
  logic        grant_vld;
  logic [3:0]  grant_idx;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;

  rr_arbiter_16 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .eop       (eop),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (grant !== 16'h0000) $display("FAIL reset_grant got=%h exp=0000", grant); else n_pass++;
    n_checks++; if (grant_vld !== 1'b0) $display("FAIL reset_vld got=%b exp=0", grant_vld); else n_pass++;
    n_checks++; if (grant_idx !== 4'd0) $display("FAIL reset_idx got=%0d exp=0", grant_idx); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else n_pass++;
    n_checks++; if (dut.ptr !== 4'd0) $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (grant !== 16'h0000) $display("FAIL post_reset_grant got=%h exp=0000", grant); else n_pass++;
    $display("reset: grant=%h vld=%b idx=%0d", grant, grant_vld, grant_idx);
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_oh;
    int port;
    req = 16'hFFFF;
    tick();
    for (int k = 0; k < 17; k++) begin
      port   = k % 16;
      exp_oh = 16'h0001 << port;
      for (int c = 1; c <= 3; c++) begin
        n_checks++;
        if (grant !== exp_oh || grant_idx !== 4'(port))
          $display("FAIL rr_grant k=%0d cyc=%0d got=%h/%0d exp=%h/%0d", k, c, grant, grant_idx, exp_oh, port);
        else n_pass++;
        eop = (c == 3) ? exp_oh : 16'h0000;
        tick();
      end
      $display("rr: grant %0d port=%0d held 3 cycles", k, port);
    end
    req = '0;
    eop = '0;
    tick();
    n_checks++; if (grant !== 16'h0000) $display("FAIL rr_drain got=%h exp=0000", grant); else n_pass++;
  endtask

  task automatic test_single();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 16'h0010;
    tick();
    n_checks++; if (grant !== 16'h0010) $display("FAIL single_grant got=%h exp=0010", grant); else n_pass++;
    n_checks++; if (grant_idx !== 4'd4) $display("FAIL single_idx got=%0d exp=4", grant_idx); else n_pass++;
    n_checks++; if (grant_vld !== 1'b1) $display("FAIL single_vld got=%b exp=1", grant_vld); else n_pass++;
    eop = 16'h0010;
    tick();
    req = '0;
    eop = '0;
    n_checks++; if (grant !== 16'h0000) $display("FAIL single_release got=%h exp=0000", grant); else n_pass++;
    n_checks++; if (grant_vld !== 1'b0) $display("FAIL single_vld_low got=%b exp=0", grant_vld); else n_pass++;
    n_checks++; if (dut.ptr !== 4'd5) $display("FAIL single_ptr got=%0d exp=5", dut.ptr); else n_pass++;
    $display("single: port 4 granted and released, ptr=%0d", dut.ptr);
  endtask

  task automatic test_wrap();
    req = 16'h0009;
    tick();
    n_checks++; if (grant !== 16'h0001) $display("FAIL wrap_first got=%h exp=0001", grant); else n_pass++;
    eop = 16'h0001;
    tick();
    eop = '0;
    n_checks++; if (grant !== 16'h0008 || grant_idx !== 4'd3) $display("FAIL wrap_second got=%h/%0d exp=0008/3", grant, grant_idx); else n_pass++;
    n_checks++; if (dut.ptr !== 4'd1) $display("FAIL wrap_ptr1 got=%0d exp=1", dut.ptr); else n_pass++;
    req = '0;
    tick();
    n_checks++; if (grant !== 16'h0000) $display("FAIL wrap_abort got=%h exp=0000", grant); else n_pass++;
    n_checks++; if (dut.ptr !== 4'd4) $display("FAIL wrap_ptr2 got=%0d exp=4", dut.ptr); else n_pass++;
    $display("wrap: ptr=5 req=0009 served port 0 then port 3");
  endtask

  task automatic test_abort();
    req = 16'h0004;
    tick();
    n_checks++; if (grant !== 16'h0004) $display("FAIL abort_first got=%h exp=0004", grant); else n_pass++;
    req = 16'h0080;
    tick();
    n_checks++; if (grant !== 16'h0080 || grant_idx !== 4'd7) $display("FAIL abort_switch got=%h/%0d exp=0080/7", grant, grant_idx); else n_pass++;
    n_checks++; if (dut.ptr !== 4'd3) $display("FAIL abort_ptr got=%0d exp=3", dut.ptr); else n_pass++;
    eop = 16'h0004;
    tick();
    n_checks++; if (grant !== 16'h0080) $display("FAIL abort_foreign_eop got=%h exp=0080", grant); else n_pass++;
    eop = '0;
    req = '0;
    tick();
    n_checks++; if (grant !== 16'h0000) $display("FAIL abort_drain got=%h exp=0000", grant); else n_pass++;
    $display("abort: port 2 aborted, port 7 granted directly");
  endtask

  task automatic test_async_reset();
    req = 16'h0040;
    tick();
    tick();
    n_checks++; if (grant !== 16'h0040) $display("FAIL areset_pre got=%h exp=0040", grant); else n_pass++;
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (grant !== 16'h0000) $display("FAIL areset_grant got=%h exp=0000", grant); else n_pass++;
    n_checks++; if (grant_vld !== 1'b0) $display("FAIL areset_vld got=%b exp=0", grant_vld); else n_pass++;
    req = '0;
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (dut.ptr !== 4'd0) $display("FAIL areset_ptr got=%0d exp=0", dut.ptr); else n_pass++;
    n_checks++; if (grant !== 16'h0000) $display("FAIL areset_idle got=%h exp=0000", grant); else n_pass++;
    $display("async_reset: grant dropped between edges, ptr=%0d", dut.ptr);
  endtask

  task automatic test_timeout();
    req = 16'h0012;
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (grant !== 16'h0002 || timeout !== 1'b0)
        $display("FAIL to_hold cyc=%0d got=%h/%b exp=0002/0", c, grant, timeout);
      else n_pass++;
      tick();
    end
    n_checks++; if (grant !== 16'h0010) $display("FAIL to_next got=%h exp=0010", grant); else n_pass++;
    n_checks++; if (timeout !== 1'b1) $display("FAIL to_pulse got=%b exp=1", timeout); else n_pass++;
    n_checks++; if (dut.ptr !== 4'd2) $display("FAIL to_ptr got=%0d exp=2", dut.ptr); else n_pass++;
    tick();
    n_checks++; if (timeout !== 1'b0) $display("FAIL to_pulse_end got=%b exp=0", timeout); else n_pass++;
    $display("timeout: port 1 forced off after 8 cycles, port 4 granted");
`else
    for (int c = 1; c <= 100; c++) begin
      n_checks++;
      if (grant !== 16'h0002 || timeout !== 1'b0)
        $display("FAIL nto_hold cyc=%0d got=%h/%b exp=0002/0", c, grant, timeout);
      else n_pass++;
      tick();
    end
    $display("timeout: disabled, port 1 held 100 cycles");
`endif
    req = '0;
    tick();
    tick();
    n_checks++; if (grant !== 16'h0000) $display("FAIL to_drain got=%h exp=0000", grant); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_abort();
    test_async_reset();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
